// File: rtl/fc_train_ctrl.sv
// Mini-batch sequencer for the FC training memory: drives load/FC1/FC2/label/back-prop
// per sample, then the weight update, and owns the shared memory write port.
module fc_train_ctrl #(
  parameter int          BCK_CELL   = 10,
  parameter int          BATCH_SIZE = 32,
  parameter logic [15:0] LABEL_ONE  = 16'h0600,
  parameter int          TIMEOUT    = 4096
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        conv_we,
  input  logic [15:0] conv_addr,
  input  logic [15:0] conv_data,
  input  logic        conv_done,
  input  logic [3:0]  label,
  input  logic        eng_we,
  input  logic [15:0] eng_addr,
  input  logic [15:0] eng_data,
  output logic        fc1_start,
  output logic        fc2_start,
  input  logic        fc1_done,
  input  logic        fc2_done,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_data,
  output logic        fc1_com_end,
  output logic        fc2_com_end,
  output logic        bck_prop_start,
  input  logic        fc_bck_prop_end,
  output logic        batch_end,
  input  logic        fc_batch_end,
  output logic [5:0]  sample_cnt,
  output logic        busy,
  output logic        batch_done,
  output logic        timeout_err
);

  localparam int WAIT_W = $clog2(TIMEOUT);
  localparam int K_W    = $clog2(BCK_CELL);
  localparam logic [WAIT_W-1:0] WAIT_LAST  = WAIT_W'(TIMEOUT - 1);
  localparam logic [K_W-1:0]    K_LAST     = K_W'(BCK_CELL - 1);
  localparam logic [5:0]        BATCH_LAST = 6'(BATCH_SIZE);

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD, S_FC1S, S_FC1W, S_FC2S, S_FC2W,
    S_LABEL, S_BPROP, S_GAP, S_UPDATE, S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q;
  logic [K_W-1:0]    k_q;
  logic [3:0]        label_q;
  logic [5:0]        sample_cnt_q;
  logic              timeout_q;
  logic              timeout_hit;
  logic              wait_expired;

  assign wait_expired = (wait_cnt_q == WAIT_LAST);

  // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    timeout_hit = 1'b0;
    unique case (state_q)
      S_IDLE:  if (start) state_d = S_LOAD;
      S_LOAD:  if (conv_done) state_d = S_FC1S;
      S_FC1S:  state_d = S_FC1W;
      S_FC1W: begin
        if (fc1_done)          state_d = S_FC2S;
        else if (wait_expired) begin state_d = S_IDLE; timeout_hit = 1'b1; end
      end
      S_FC2S:  state_d = S_FC2W;
      S_FC2W: begin
        if (fc2_done)          state_d = S_LABEL;
        else if (wait_expired) begin state_d = S_IDLE; timeout_hit = 1'b1; end
      end
      S_LABEL: if (k_q == K_LAST) state_d = S_BPROP;
      S_BPROP: begin
        if (fc_bck_prop_end)   state_d = S_GAP;
        else if (wait_expired) begin state_d = S_IDLE; timeout_hit = 1'b1; end
      end
      S_GAP:   state_d = (sample_cnt_q + 6'd1 == BATCH_LAST) ? S_UPDATE : S_LOAD;
      S_UPDATE: begin
        if (fc_batch_end)      state_d = S_DONE;
        else if (wait_expired) begin state_d = S_IDLE; timeout_hit = 1'b1; end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Moore decode of the control lines plus the write-port mux.
  always_comb begin
    fc1_start      = (state_q == S_FC1S);
    fc2_start      = (state_q == S_FC2S);
    bck_prop_start = (state_q == S_BPROP);
    batch_end      = (state_q == S_UPDATE);
    batch_done     = (state_q == S_DONE);
    busy           = (state_q != S_IDLE);
    fc1_com_end    = 1'b0;
    fc2_com_end    = 1'b0;
    mem_we         = 1'b0;
    mem_addr       = 16'h0000;
    mem_data       = 16'h0000;
    unique case (state_q)
      S_LOAD: begin
        mem_we   = conv_we;
        mem_addr = conv_addr;
        mem_data = conv_data;
      end
      S_FC1W: begin
        mem_we   = eng_we;
        mem_addr = eng_addr;
        mem_data = eng_data;
      end
      S_FC2S: fc1_com_end = 1'b1;
      S_FC2W: begin
        fc1_com_end = 1'b1;
        mem_we      = eng_we;
        mem_addr    = eng_addr;
        mem_data    = eng_data;
      end
      S_LABEL: begin
        fc1_com_end = 1'b1;
        fc2_com_end = 1'b1;
        mem_we      = 1'b1;
        mem_addr    = 16'(BCK_CELL) + 16'(k_q);
        // An out-of-range label never matches k, so the whole vector is written as zeros.
        mem_data    = ({12'h000, label_q} == 16'(k_q)) ? LABEL_ONE : 16'h0000;
      end
      S_BPROP, S_GAP: begin
        fc1_com_end = 1'b1;
        fc2_com_end = 1'b1;
      end
      default: ;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      wait_cnt_q   <= '0;
      k_q          <= '0;
      label_q      <= '0;
      sample_cnt_q <= '0;
      timeout_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= (state_d != state_q) ? '0 : wait_cnt_q + WAIT_W'(1);
      k_q        <= (state_q == S_LABEL) ? k_q + K_W'(1) : '0;
      if (state_q == S_LOAD && conv_done) label_q <= label;
      if (state_q == S_IDLE && start) begin
        sample_cnt_q <= '0;
        timeout_q    <= 1'b0;
      end
      if (state_q == S_GAP) sample_cnt_q <= sample_cnt_q + 6'd1;
      if (timeout_hit)      timeout_q    <= 1'b1;
    end
  end

  assign sample_cnt  = sample_cnt_q;
  assign timeout_err = timeout_q;

endmodule

// File: tb/tb_fc_train_ctrl.sv
// Self-checking bench for fc_train_ctrl: write-port scoreboard, mux vector table,
// full batch, single-sample batch, timeout and mid-batch reset sequences.
module tb_fc_train_ctrl;

  localparam int          BCK_CELL  = 10;
  localparam int          TIMEOUT   = 16;
  localparam logic [15:0] LABEL_ONE = 16'h0600;

  logic        clk = 1'b0, reset_n = 1'b0, start = 1'b0;
  logic        conv_we = 1'b0, conv_done = 1'b0, eng_we = 1'b0;
  logic [15:0] conv_addr = '0, conv_data = '0, eng_addr = '0, eng_data = '0;
  logic [3:0]  label = '0;
  logic        fc1_done = 1'b0, fc2_done = 1'b0, fc_bck_prop_end = 1'b0, fc_batch_end = 1'b0;

  logic        d_fc1_start, d_fc2_start, d_mem_we, d_fc1_com_end, d_fc2_com_end;
  logic        d_bck_prop_start, d_batch_end, d_busy, d_batch_done, d_timeout_err;
  logic [15:0] d_mem_addr, d_mem_data;
  logic [5:0]  d_sample_cnt;
  logic        o_fc1_start, o_fc2_start, o_mem_we, o_fc1_com_end, o_fc2_com_end;
  logic        o_bck_prop_start, o_batch_end, o_busy, o_batch_done, o_timeout_err;
  logic [15:0] o_mem_addr, o_mem_data;
  logic [5:0]  o_sample_cnt;

  fc_train_ctrl #(.BCK_CELL(BCK_CELL), .BATCH_SIZE(32), .LABEL_ONE(LABEL_ONE), .TIMEOUT(TIMEOUT)) u_dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .conv_we(conv_we), .conv_addr(conv_addr), .conv_data(conv_data),
    .conv_done(conv_done), .label(label),
    .eng_we(eng_we), .eng_addr(eng_addr), .eng_data(eng_data),
    .fc1_start(d_fc1_start), .fc2_start(d_fc2_start), .fc1_done(fc1_done), .fc2_done(fc2_done),
    .mem_we(d_mem_we), .mem_addr(d_mem_addr), .mem_data(d_mem_data),
    .fc1_com_end(d_fc1_com_end), .fc2_com_end(d_fc2_com_end),
    .bck_prop_start(d_bck_prop_start), .fc_bck_prop_end(fc_bck_prop_end),
    .batch_end(d_batch_end), .fc_batch_end(fc_batch_end),
    .sample_cnt(d_sample_cnt), .busy(d_busy), .batch_done(d_batch_done), .timeout_err(d_timeout_err)
  );

  fc_train_ctrl #(.BCK_CELL(BCK_CELL), .BATCH_SIZE(1), .LABEL_ONE(LABEL_ONE), .TIMEOUT(TIMEOUT)) u_one (
    .clk(clk), .reset_n(reset_n), .start(start),
    .conv_we(conv_we), .conv_addr(conv_addr), .conv_data(conv_data),
    .conv_done(conv_done), .label(label),
    .eng_we(eng_we), .eng_addr(eng_addr), .eng_data(eng_data),
    .fc1_start(o_fc1_start), .fc2_start(o_fc2_start), .fc1_done(fc1_done), .fc2_done(fc2_done),
    .mem_we(o_mem_we), .mem_addr(o_mem_addr), .mem_data(o_mem_data),
    .fc1_com_end(o_fc1_com_end), .fc2_com_end(o_fc2_com_end),
    .bck_prop_start(o_bck_prop_start), .fc_bck_prop_end(fc_bck_prop_end),
    .batch_end(o_batch_end), .fc_batch_end(fc_batch_end),
    .sample_cnt(o_sample_cnt), .busy(o_busy), .batch_done(o_batch_done), .timeout_err(o_timeout_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int d_done_cnt = 0;
  int o_done_cnt = 0;
  logic [31:0] label_exp_q[$];
  logic [31:0] pass_exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // {busy, fc1_start, fc2_start, bck_prop_start, batch_end, batch_done, timeout_err, mem_we, sel}
  function automatic logic [31:0] ctrl_d();
    return {22'd0, d_busy, d_fc1_start, d_fc2_start, d_bck_prop_start, d_batch_end,
            d_batch_done, d_timeout_err, d_mem_we, d_fc1_com_end, d_fc2_com_end};
  endfunction

  function automatic logic sig(input int w);
    case (w)
      0:       return d_fc1_start;
      1:       return d_fc2_start;
      2:       return d_bck_prop_start;
      default: return 1'b0;
    endcase
  endfunction

  // Scoreboard: every write seen on the memory port must match the oldest expected one.
  always @(negedge clk) begin
    if (reset_n && d_mem_we) begin
      if (d_fc2_com_end) begin
        check("label_bank_sel", {31'd0, d_fc1_com_end}, 32'd1);
        if (label_exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL label_write: unexpected write %0h/%0h, required none", d_mem_addr, d_mem_data);
        end else check("label_write", {d_mem_addr, d_mem_data}, label_exp_q.pop_front());
      end else begin
        if (pass_exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL pass_write: unexpected write %0h/%0h, required none", d_mem_addr, d_mem_data);
        end else check("pass_write", {d_mem_addr, d_mem_data}, pass_exp_q.pop_front());
      end
    end
    if (d_batch_done) d_done_cnt++;
    if (o_batch_done) o_done_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_sig(input int w, input string nm, input int limit);
    for (int n = 0; n <= limit; n++) begin
      @(negedge clk);
      if (sig(w)) return;
    end
    checks++; errors++;
    $display("FAIL wait_%s: not seen within %0d cycles, required 1", nm, limit);
  endtask

  task automatic kick_load(input logic [3:0] lbl, input bit push);
    if (push)
      for (int k = 0; k < BCK_CELL; k++)
        label_exp_q.push_back({16'(BCK_CELL + k), (k == int'(lbl)) ? LABEL_ONE : 16'h0000});
    label = lbl;
    conv_done = 1'b1;
    tick();
    conv_done = 1'b0;
  endtask

  task automatic finish_fc1(input int dly);
    wait_sig(0, "fc1_start", 4);
    @(negedge clk);
    check("fc1_start_pulse", {31'd0, d_fc1_start}, 32'd0);
    tick();
    repeat (dly) tick();
    fc1_done = 1'b1;
    tick();
    fc1_done = 1'b0;
  endtask

  task automatic finish_fc2(input int dly);
    wait_sig(1, "fc2_start", 4);
    @(negedge clk);
    check("fc2_start_pulse", {31'd0, d_fc2_start}, 32'd0);
    check("fc2w_sel", {30'd0, d_fc1_com_end, d_fc2_com_end}, 32'b10);
    tick();
    repeat (dly) tick();
    fc2_done = 1'b1;
    tick();
    fc2_done = 1'b0;
  endtask

  task automatic finish_bp(input int dly);
    wait_sig(2, "bck_prop_start", BCK_CELL + 4);
    check("label_drained", 32'(label_exp_q.size()), 32'd0);
    check("bprop_sel", {30'd0, d_fc1_com_end, d_fc2_com_end}, 32'b11);
    tick();
    repeat (dly) tick();
    fc_bck_prop_end = 1'b1;
    @(negedge clk);
    check("bprop_held", {31'd0, d_bck_prop_start}, 32'd1);
    tick();
    fc_bck_prop_end = 1'b0;
    @(negedge clk);
    check("gap_bprop_low", {31'd0, d_bck_prop_start}, 32'd0);
    tick();
  endtask

  task automatic run_sample(input logic [3:0] lbl, input int dly);
    kick_load(lbl, 1'b1);
    finish_fc1(dly);
    finish_fc2(dly);
    finish_bp(dly);
  endtask

  typedef struct {
    int          ph;
    logic        cw;
    logic [15:0] ca, cd;
    logic        ew;
    logic [15:0] ea, ed;
    logic        exp_we;
    logic [31:0] exp_w;
    logic [1:0]  exp_sel;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int cyc;
    // phase 0 = LOAD, 1 = FC1W, 2 = FC2W
    vecs[0] = '{0, 1'b1, 16'h0040, 16'h1234, 1'b0, 16'h0000, 16'h0000, 1'b1, 32'h0040_1234, 2'b00};
    vecs[1] = '{0, 1'b0, 16'h0041, 16'h5555, 1'b1, 16'h0099, 16'hdead, 1'b0, 32'h0,         2'b00};
    vecs[2] = '{0, 1'b1, 16'h0042, 16'h0abc, 1'b1, 16'h0098, 16'hbeef, 1'b1, 32'h0042_0abc, 2'b00};
    vecs[3] = '{1, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0200, 16'h1111, 1'b1, 32'h0200_1111, 2'b00};
    vecs[4] = '{1, 1'b1, 16'h0043, 16'h2222, 1'b0, 16'h0000, 16'h0000, 1'b0, 32'h0,         2'b00};
    vecs[5] = '{1, 1'b1, 16'h0044, 16'h3333, 1'b1, 16'h0201, 16'h4444, 1'b1, 32'h0201_4444, 2'b00};
    vecs[6] = '{2, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0300, 16'h5678, 1'b1, 32'h0300_5678, 2'b10};
    vecs[7] = '{2, 1'b1, 16'h0045, 16'h6666, 1'b0, 16'h0000, 16'h0000, 1'b0, 32'h0,         2'b10};

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_ctrl", ctrl_d(), 32'd0);
    check("reset_bus", {d_mem_addr, d_mem_data}, 32'd0);
    check("reset_sample_cnt", 32'(d_sample_cnt), 32'd0);
    tick();
    reset_n = 1'b1;

    // Start: LOAD one cycle later, sample counter cleared
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    @(negedge clk);
    check("start_latency", ctrl_d(), 32'b10_0000_0000);
    check("start_sample_cnt", 32'(d_sample_cnt), 32'd0);
    tick();

    // Sample 1 (label 3) with the write-port mux table
    begin
      int cur;
      cur = 0;
      for (int i = 0; i < 8; i++) begin
        if (vecs[i].ph != cur) begin
          if (cur == 0) begin
            kick_load(4'd3, 1'b1);
            tick();
          end else begin
            fc1_done = 1'b1;
            tick();
            fc1_done = 1'b0;
            tick();
          end
          cur = vecs[i].ph;
        end
        conv_we = vecs[i].cw; conv_addr = vecs[i].ca; conv_data = vecs[i].cd;
        eng_we  = vecs[i].ew; eng_addr  = vecs[i].ea; eng_data  = vecs[i].ed;
        if (vecs[i].exp_we) pass_exp_q.push_back(vecs[i].exp_w);
        @(negedge clk);
        check($sformatf("mux_sel_%0d", i), {30'd0, d_fc1_com_end, d_fc2_com_end}, 32'(vecs[i].exp_sel));
        tick();
        conv_we = 1'b0; eng_we = 1'b0;
        conv_addr = '0; conv_data = '0; eng_addr = '0; eng_data = '0;
      end
    end
    check("mux_drained", 32'(pass_exp_q.size()), 32'd0);
    fc2_done = 1'b1;
    tick();
    fc2_done = 1'b0;
    finish_bp(5);

    // BATCH_SIZE=1 instance went to UPDATE, the 32-sample one back to LOAD
    @(negedge clk);
    check("one_batch_end", {31'd0, o_batch_end}, 32'd1);
    check("one_sample_cnt", 32'(o_sample_cnt), 32'd1);
    check("one_sel_update", {30'd0, o_fc1_com_end, o_fc2_com_end}, 32'd0);
    check("dut_after_s1", ctrl_d(), 32'b10_0000_0000);
    check("dut_sample_cnt_1", 32'(d_sample_cnt), 32'd1);
    tick();
    fc_batch_end = 1'b1;
    tick();
    fc_batch_end = 1'b0;
    @(negedge clk);
    check("one_batch_done", {30'd0, o_batch_done, o_batch_end}, 32'b10);
    tick();
    @(negedge clk);
    check("one_idle", {30'd0, o_busy, o_batch_done}, 32'd0);
    check("one_done_once", 32'(o_done_cnt), 32'd1);
    check("one_cnt_hold", 32'(o_sample_cnt), 32'd1);
    check("dut_ignores_batch_end", ctrl_d(), 32'b10_0000_0000);
    tick();

    // Remaining samples of the full batch; sample 5 has an out-of-range label
    for (int s = 2; s <= 32; s++) begin
      run_sample((s == 5) ? 4'd12 : 4'(s % 10), 5);
      @(negedge clk);
      check($sformatf("sample_cnt_%0d", s), 32'(d_sample_cnt), 32'(s));
      if (s < 32) check($sformatf("no_batch_end_%0d", s), {31'd0, d_batch_end}, 32'd0);
      else        check("update_ctrl", ctrl_d(), 32'b10_0010_0000);
      tick();
      if (s == 2) begin
        start = 1'b1;
        tick();
        start = 1'b0;
        @(negedge clk);
        check("start_ignored_cnt", 32'(d_sample_cnt), 32'd2);
        tick();
      end
    end
    fc_batch_end = 1'b1;
    tick();
    fc_batch_end = 1'b0;
    @(negedge clk);
    check("done_ctrl", ctrl_d(), 32'b10_0001_0000);
    tick();
    @(negedge clk);
    check("batch_idle", ctrl_d(), 32'd0);
    check("batch_sample_cnt", 32'(d_sample_cnt), 32'd32);
    check("batch_done_once", 32'(d_done_cnt), 32'd1);
    tick();

    // Timeout in FC2W
    start = 1'b1;
    tick();
    start = 1'b0;
    kick_load(4'd7, 1'b0);
    finish_fc1(2);
    wait_sig(1, "fc2_start_to", 4);
    cyc = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (!d_busy) break;
      cyc++;
    end
    check("timeout_cycles", 32'(cyc), 32'(TIMEOUT));
    check("timeout_ctrl", ctrl_d(), 32'b00_0000_1000);
    check("timeout_bus", {d_mem_addr, d_mem_data}, 32'd0);
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    @(negedge clk);
    check("timeout_cleared", ctrl_d(), 32'b10_0000_0000);
    tick();

    // Reset asserted during BPROP
    kick_load(4'd4, 1'b1);
    finish_fc1(1);
    finish_fc2(1);
    wait_sig(2, "bck_prop_start_rst", BCK_CELL + 4);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_reset_ctrl", ctrl_d(), 32'd0);
    check("async_reset_bus", {d_mem_addr, d_mem_data}, 32'd0);
    check("async_reset_cnt", 32'(d_sample_cnt), 32'd0);
    tick();
    reset_n = 1'b1;
    @(negedge clk);
    check("post_reset_idle", ctrl_d(), 32'd0);
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    run_sample(4'd9, 3);
    @(negedge clk);
    check("clean_sample_cnt", 32'(d_sample_cnt), 32'd1);
    check("clean_load", ctrl_d(), 32'b10_0000_0000);
    check("queues_empty", 32'(label_exp_q.size() + pass_exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
